// File: rtl/muldiv_exec_unit.sv
// Iterative unsigned multiply/divide unit (MUL_LO/MUL_HI/DIV_Q/DIV_R), one bit per cycle.
// Latency: fixed WIDTH step cycles after the accept edge, then a one-cycle done/wb_en pulse.
// Backpressure: none; start is only sampled in IDLE and is dropped while busy.
module muldiv_exec_unit #(
    parameter int WIDTH      = 16,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [WIDTH-1:0]      operand_a,
    input  logic [WIDTH-1:0]      operand_b,
    input  logic [REG_ADDR_W-1:0] dest_reg,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      result,
    output logic [REG_ADDR_W-1:0] wb_reg,
    output logic                  wb_en,
    output logic                  div_by_zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] OP_MUL_LO = 2'b00;
    localparam logic [1:0] OP_MUL_HI = 2'b01;
    localparam logic [1:0] OP_DIV_Q  = 2'b10;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        count;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     op_a_q;
    logic [WIDTH-1:0]     op_b_q;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     quo;

    logic                 accept;
    logic                 last_step;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   prod_step;
    logic [WIDTH:0]       div_shift;
    logic                 div_fits;
    logic [WIDTH-1:0]     div_diff;
    logic [WIDTH-1:0]     rem_step;
    logic [WIDTH-1:0]     quo_step;
    logic [WIDTH-1:0]     step_result;

    assign accept    = (state == IDLE) && start;
    assign last_step = (state == CALC) && (count == LAST);

    // Shift-add: low half of prod holds the remaining multiplier bits.
    assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, op_a_q} : '0);
    assign prod_step = {mul_sum, prod[WIDTH-1:1]};

    // Restoring divide; a zero divisor always "fits", giving all-ones quotient and rem=dividend.
    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_fits  = div_shift >= {1'b0, op_b_q};
    assign div_diff  = div_shift[WIDTH-1:0] - op_b_q;
    assign rem_step  = div_fits ? div_diff : div_shift[WIDTH-1:0];
    assign quo_step  = {quo[WIDTH-2:0], div_fits};

    always_comb begin
        step_result = rem_step;
        case (op_q)
            OP_MUL_LO: step_result = prod_step[WIDTH-1:0];
            OP_MUL_HI: step_result = prod_step[2*WIDTH-1:WIDTH];
            OP_DIV_Q:  step_result = quo_step;
            default:   step_result = rem_step;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (count == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            op_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            prod        <= '0;
            rem         <= '0;
            quo         <= '0;
            result      <= '0;
            wb_reg      <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= last_step;
            if (accept) begin
                count       <= '0;
                op_q        <= op;
                op_a_q      <= operand_a;
                op_b_q      <= operand_b;
                wb_reg      <= dest_reg;
                prod        <= {{WIDTH{1'b0}}, operand_b};
                rem         <= '0;
                quo         <= operand_a;
                div_by_zero <= 1'b0;
            end else if (state == CALC) begin
                count <= count + 1'b1;
                prod  <= prod_step;
                rem   <= rem_step;
                quo   <= quo_step;
                if (last_step) begin
                    result      <= step_result;
                    div_by_zero <= op_q[1] && (op_b_q == '0);
                end
            end
        end
    end

    assign busy  = (state != IDLE);
    assign wb_en = done;

endmodule

// File: tb/tb_muldiv_exec_unit.sv
// Directed bench for muldiv_exec_unit: vector table plus interlock and mid-op reset sequences.
module tb_muldiv_exec_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic [3:0]  dest_reg;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [3:0]  wb_reg;
    logic        wb_en;
    logic        div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_exec_unit #(.WIDTH(16), .REG_ADDR_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .dest_reg    (dest_reg),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .wb_reg      (wb_reg),
        .wb_en       (wb_en),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  dest;
        logic [15:0] exp_res;
        logic        exp_dbz;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits for the done pulse; lat counts edges after the accept edge (-1 on timeout).
    task automatic wait_done(output int lat, output logic [15:0] r, output logic z,
                             output logic [3:0] wr);
        lat = -1;
        r   = '0;
        z   = 1'b0;
        wr  = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                r   = result;
                z   = div_by_zero;
                wr  = wb_reg;
                chk("wb_en_with_done", wb_en, 1);
                break;
            end
        end
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("wb_en_one_cycle", wb_en, 0);
        chk("idle_after_done", busy, 0);
    endtask

    task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] d, output int lat, output logic [15:0] r,
                         output logic z, output logic [3:0] wr);
        @(negedge clk);
        start = 1'b1; op = o; operand_a = a; operand_b = b; dest_reg = d;
        @(posedge clk); #1;
        // Scramble inputs: only latched copies may matter from here on.
        start = 1'b0;
        op = 2'($urandom); operand_a = 16'($urandom); operand_b = 16'($urandom);
        dest_reg = 4'($urandom);
        chk("busy_after_accept", busy, 1);
        wait_done(lat, r, z, wr);
    endtask

    initial begin
        int          lat;
        logic [15:0] r;
        logic        z;
        logic [3:0]  wr;
        int          dcnt;
        int          first;
        int          wb_seen;

        vecs[0]  = '{2'b00, 16'h1234, 16'h0010, 4'd3,  16'h2340, 1'b0};
        vecs[1]  = '{2'b01, 16'h1234, 16'h0010, 4'd3,  16'h0001, 1'b0};
        vecs[2]  = '{2'b10, 16'h0064, 16'h0007, 4'd1,  16'h000E, 1'b0};
        vecs[3]  = '{2'b11, 16'h0064, 16'h0007, 4'd2,  16'h0002, 1'b0};
        vecs[4]  = '{2'b10, 16'hFFFF, 16'hFFFF, 4'd4,  16'h0001, 1'b0};
        vecs[5]  = '{2'b11, 16'hFFFF, 16'hFFFF, 4'd5,  16'h0000, 1'b0};
        vecs[6]  = '{2'b10, 16'h00AB, 16'h0000, 4'd7,  16'hFFFF, 1'b1};
        vecs[7]  = '{2'b11, 16'h00AB, 16'h0000, 4'd8,  16'h00AB, 1'b1};
        vecs[8]  = '{2'b00, 16'h0003, 16'h0005, 4'd9,  16'h000F, 1'b0};
        vecs[9]  = '{2'b01, 16'hFFFF, 16'hFFFF, 4'd14, 16'hFFFE, 1'b0};
        vecs[10] = '{2'b00, 16'hFFFF, 16'hFFFF, 4'd15, 16'h0001, 1'b0};

        reset = 1'b1; start = 1'b0; op = 2'b11;
        operand_a = 16'hDEAD; operand_b = 16'hBEEF; dest_reg = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_result", result, 0);
        chk("rst_wb_reg", wb_reg, 0);
        chk("rst_dbz", div_by_zero, 0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest, lat, r, z, wr);
            chk($sformatf("v%0d_latency", i), lat, 16);
            chk($sformatf("v%0d_result", i), r, vecs[i].exp_res);
            chk($sformatf("v%0d_dbz", i), z, vecs[i].exp_dbz);
            chk($sformatf("v%0d_wb_reg", i), wr, vecs[i].dest);
        end

        // Busy interlock: starts at cycle 4 and in the DONE cycle are ignored; next IDLE accepts.
        @(negedge clk);
        start = 1'b1; op = 2'b00; operand_a = 16'd2; operand_b = 16'd3; dest_reg = 4'd5;
        @(posedge clk); #1;
        dcnt = 0; first = -1; r = '0; wr = '0;
        for (int k = 1; k <= 18; k++) begin
            start     = (k == 4) || (k >= 17);
            op        = 2'b10;
            operand_a = (k == 4 || k >= 17) ? 16'd9 : 16'(k * 37);
            operand_b = (k == 4 || k >= 17) ? 16'd3 : 16'(k);
            dest_reg  = 4'd6;
            @(posedge clk); #1;
            if (done) begin
                dcnt++;
                if (first < 0) first = k;
                r  = result;
                wr = wb_reg;
            end
        end
        start = 1'b0;
        chk("ilk_done_count", dcnt, 1);
        chk("ilk_done_cycle", first, 16);
        chk("ilk_result", r, 16'h0006);
        chk("ilk_wb_reg", wr, 4'd5);
        chk("ilk_next_accepted", busy, 1);
        wait_done(lat, r, z, wr);
        chk("ilk2_latency", lat, 16);
        chk("ilk2_result", r, 16'h0003);
        chk("ilk2_wb_reg", wr, 4'd6);

        // Reset in the middle of a divide.
        @(negedge clk);
        start = 1'b1; op = 2'b10; operand_a = 16'h8000; operand_b = 16'd2; dest_reg = 4'd10;
        @(posedge clk); #1;
        start = 1'b0;
        wb_seen = 0;
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) reset = 1'b1;
            @(posedge clk); #1;
            if (wb_en) wb_seen++;
        end
        reset = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_result", result, 0);
        chk("midrst_done", done, 0);
        for (int k = 0; k < 24; k++) begin
            @(posedge clk); #1;
            if (wb_en) wb_seen++;
        end
        chk("midrst_no_wb_en", wb_seen, 0);
        do_op(2'b00, 16'h00FF, 16'h0101, 4'd11, lat, r, z, wr);
        chk("postrst_latency", lat, 16);
        chk("postrst_result", r, 16'hFFFF);
        chk("postrst_wb_reg", wr, 4'd11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_exec_unit.md
Name: muldiv_exec_unit

Overview:
- Multi-cycle unsigned multiply/divide execute unit for the 16-bit core.
- Sits downstream of the register file: consumes the two register read operands and the destination register index.
- Returns a single-cycle write-back (register index, data, write enable) that drives the register file write port.
- Iterative 1-bit-per-cycle algorithm; fixed 16-cycle latency for every op.

Parameters:
- WIDTH, 16, operand/result width; the counter and algorithm scale with it.
- REG_ADDR_W, 4, destination register index width (16 registers).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  2  00=MUL_LO, 01=MUL_HI, 10=DIV_Q, 11=DIV_R (all unsigned)
- operand_a  in  WIDTH  multiplicand / dividend (register read port 1)
- operand_b  in  WIDTH  multiplier / divisor (register read port 2)
- dest_reg  in  REG_ADDR_W  write-back register index
- busy  out  1  high in CALC and DONE
- done  out  1  one-cycle pulse; result valid
- result  out  WIDTH  registered result, held until next accept
- wb_reg  out  REG_ADDR_W  latched dest_reg
- wb_en  out  1  register-file write enable; equals done
- div_by_zero  out  1  valid with done; set for DIV ops with operand_b==0

Behaviour:
- Reset (sync) values: state=IDLE, busy=0, done=0, wb_en=0, result=0, wb_reg=0, div_by_zero=0, count=0, internal accumulators=0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - On an edge with start=1, latch op, operand_a, operand_b, dest_reg into wb_reg; clear count; go to CALC.
  - done, wb_en and div_by_zero drop to 0 on accept. result holds its old value until DONE.
- CALC: one algorithm step per edge; count increments 0..WIDTH-1. The step performed at count==WIDTH-1 writes result and goes to DONE.
- MUL algorithm:
  - Shift-add, 2*WIDTH-bit product register.
  - MUL_LO returns product[WIDTH-1:0]; MUL_HI returns product[2*WIDTH-1:WIDTH].
  - No overflow flag.
- DIV algorithm:
  - Restoring division with a WIDTH+1-bit partial remainder.
  - DIV_Q returns the quotient; DIV_R returns the remainder.
- Divide by zero:
  - Must not be special-cased in the datapath. The restoring algorithm naturally yields quotient=all-ones (0xFFFF) and remainder=operand_a.
  - div_by_zero=1 in DONE for DIV_Q/DIV_R when the latched operand_b==0; always 0 for MUL ops.
- DONE: done=1, wb_en=1 for exactly one cycle, then IDLE on the next edge unconditionally.
- Latency: accept edge E0, steps at E1..E16, done/wb_en high during the cycle after E16, IDLE after E17.
- start while busy (CALC or DONE):
  - Ignored, not queued.
  - Operand/op input changes while busy have no effect; only latched copies are used.
- Back-to-back: the earliest next accept is the first IDLE cycle after DONE. Max throughput is one op per 18 cycles.
- Reset mid-operation: returns to IDLE next edge. No wb_en pulse is ever produced for the aborted op; result is cleared to 0.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- MUL_LO/MUL_HI: a=0x1234, b=0x0010 -> after 16 cycles, MUL_LO result=0x2340 and MUL_HI result=0x0001. wb_en=1 for one cycle with wb_reg=dest_reg=3; div_by_zero=0.
- DIV_Q/DIV_R: a=100 (0x0064), b=7 -> DIV_Q result=0x000E, DIV_R result=0x0002; done exactly 16 cycles after the accept edge. Also a=0xFFFF, b=0xFFFF -> Q=0x0001, R=0x0000.
- Divide by zero: a=0x00AB, b=0 -> DIV_Q=0xFFFF, DIV_R=0x00AB, div_by_zero=1 with done. Then MUL 3*5 -> result 0x000F, div_by_zero=0.
- Busy interlock: accept MUL 2*3, then pulse start with DIV 9/3 and change operands at cycles 4 and 16 (DONE).
  - Only one done pulse, with result=0x0006.
  - A new start in the following IDLE cycle is accepted and produces 0x0003.
- Reset mid-operation: accept DIV 0x8000/2, assert reset at cycle 5 for one cycle.
  - busy=0 and result=0 next cycle; wb_en never asserts.
  - A subsequent MUL 0x00FF*0x0101 yields MUL_LO=0xFFFF.
- Max operand: MUL_HI 0xFFFF*0xFFFF -> 0xFFFE; MUL_LO -> 0x0001; wb_en is high for exactly one cycle per op.
